// File: rtl/alu_pkg.sv
// Shared ALU opcodes and multiply-sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SHL1 = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } mulState_t;

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU shared between the main datapath and the multiply sequencer.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_din1,
  input  logic [WIDTH-1:0] i_din2,
  output logic [WIDTH-1:0] o_result
);

  // SHL1 shifts din2 so the sequencer can double the multiplicand with din1 = 0.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND:  o_result = i_din1 & i_din2;
      OP_OR:   o_result = i_din1 | i_din2;
      OP_ADD:  o_result = i_din1 + i_din2;
      OP_SUB:  o_result = i_din1 - i_din2;
      OP_SLT:  o_result = WIDTH'($signed(i_din1) < $signed(i_din2));
      OP_NOR:  o_result = ~(i_din1 | i_din2);
      OP_SHL1: o_result = i_din2 << 1;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU, stalling the datapath while it owns it.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  input  logic [3:0]       dp_op,
  input  logic [WIDTH-1:0] dp_a,
  input  logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  mulState_t        r_state;
  mulState_t        w_nextState;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_product;
  logic             w_lastShift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // The counter bound is a safety net; an empty multiplier normally ends the loop first.
  assign w_lastShift = ((r_mplier >> 1) == '0) || (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_nextState = r_state;
    alu_op      = dp_op;
    alu_a       = dp_a;
    alu_b       = dp_b;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (mul_b == '0)   w_nextState = ST_DONE;
          else if (mul_b[0]) w_nextState = ST_ADD;
          else               w_nextState = ST_SHIFT;
        end
      end
      ST_ADD: begin
        alu_op      = OP_ADD;
        alu_a       = r_acc;
        alu_b       = r_mcand;
        w_nextState = ST_SHIFT;
      end
      ST_SHIFT: begin
        alu_op = OP_SHL1;
        alu_a  = '0;
        alu_b  = r_mcand;
        if (w_lastShift)      w_nextState = ST_DONE;
        else if (r_mplier[1]) w_nextState = ST_ADD;
        else                  w_nextState = ST_SHIFT;
      end
      ST_DONE: begin
        alu_op      = OP_ADD;
        alu_a       = '0;
        alu_b       = '0;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand  <= mul_a;
            r_mplier <= mul_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_ADD:   r_acc <= alu_result;
        ST_SHIFT: begin
          r_mcand  <= alu_result;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        ST_DONE:  r_product <= r_acc;
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign stall   = busy;
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq wired to the shared ALU.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] mul_a, mul_b;
  logic [3:0]  dp_op;
  logic [31:0] dp_a, dp_b;
  logic [31:0] alu_result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        busy, stall, done;
  logic [31:0] product;

  int checks = 0;
  int failures = 0;
  logic [31:0] lastProduct = 32'd0;

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .mul_a(mul_a), .mul_b(mul_b),
    .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b), .alu_result(alu_result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .busy(busy), .stall(stall), .done(done), .product(product)
  );

  alu #(.WIDTH(32)) uAlu (
    .i_op(alu_op), .i_din1(alu_a), .i_din2(alu_b), .o_result(alu_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int popCount(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int msbIndex(input logic [31:0] v);
    int m = -1;
    for (int i = 0; i < 32; i++) if (v[i]) m = i;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full multiply: accept, watch the busy window, check done timing and the product.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit pokeStart);
    int expLat, cyc, doneCount;
    bit seen;
    logic [31:0] expProd;
    expProd = a * b;
    expLat  = (b == 32'd0) ? 1 : 1 + popCount(b) + msbIndex(b) + 1;
    start = 1'b1;
    mul_a = a;
    mul_b = b;
    tick();
    start = 1'b0;
    mul_a = $urandom;
    mul_b = $urandom;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= expLat + 5) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        checkOutput("busyDuringRun", {31'd0, busy}, 32'd1);
        checkOutput("stallDuringRun", {31'd0, stall}, 32'd1);
        checkOutput("productHeldRun", product, lastProduct);
        dp_op = OP_NOR;
        dp_a  = $urandom;
        dp_b  = $urandom;
        #1;
        if (alu_op == OP_NOR) checkOutput("dpLeakOp", {28'd0, alu_op}, {28'd0, OP_ADD});
        if (pokeStart && cyc == 2) begin
          start = 1'b1;
          mul_a = a + 32'd11;
          mul_b = b ^ 32'h5;
        end else begin
          start = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    checkOutput("doneSeen", {31'd0, seen}, 32'd1);
    checkOutput("latency", cyc, expLat);
    checkOutput("busyInDone", {31'd0, busy}, 32'd1);
    checkOutput("doneAluA", alu_a, 32'd0);
    checkOutput("productBeforeDone", product, lastProduct);
    tick();
    checkOutput("donePulseEnd", {31'd0, done}, 32'd0);
    checkOutput("busyAfterDone", {31'd0, busy}, 32'd0);
    checkOutput("product", product, expProd);
    lastProduct = expProd;
    checkOutput("idlePassOp", {28'd0, alu_op}, {28'd0, dp_op});
    checkOutput("idlePassA", alu_a, dp_a);
    if (pokeStart) begin
      doneCount = 0;
      for (int i = 0; i < 8; i++) begin
        if (done || busy) doneCount++;
        tick();
      end
      checkOutput("noSecondRun", doneCount, 0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, mask;
    int doneCount;
    reset = 1'b1;
    start = 1'b0;
    mul_a = '0;
    mul_b = '0;
    dp_op = OP_ADD;
    dp_a  = 32'd5;
    dp_b  = 32'd7;
    tick();
    tick();
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstStall", {31'd0, stall}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstProduct", product, 32'd0);
    checkOutput("idleAluResult", alu_result, 32'd12);
    checkOutput("idleAluOp", {28'd0, alu_op}, {28'd0, OP_ADD});
    reset = 1'b0;
    tick();
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);

    applyStimulus(32'd6, 32'd3, 1'b1);
    applyStimulus(32'd9, 32'd0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
    applyStimulus(32'h8000_0000, 32'd2, 1'b0);
    applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b0);
    applyStimulus(32'd5, 32'h8000_0000, 1'b0);
    applyStimulus(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);

    // Abandon a multiply with reset and make sure nothing completes.
    start = 1'b1;
    mul_a = 32'd7;
    mul_b = 32'hFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("midRunBusy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("midRstDone", {31'd0, done}, 32'd0);
    checkOutput("midRstProduct", product, 32'd0);
    lastProduct = 32'd0;
    tick();
    reset = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) doneCount++;
      tick();
    end
    checkOutput("noDoneAfterRst", doneCount, 0);
    applyStimulus(32'd7, 32'hFF, 1'b0);
    checkOutput("product7xFF", lastProduct, 32'h6F9);

    for (int n = 0; n < 24; n++) begin
      ra   = $urandom;
      mask = (32'd1 << $urandom_range(1, 32)) - 32'd1;
      rb   = $urandom & mask;
      applyStimulus(ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
